rr_arb256: RTL and testbench
============================

Name: rr_arb256

Overview:
- Round-robin arbiter that shares one downstream resource among 256 requesters.
- Arbitration core is two pe256 priority encoders: one on the masked request vector, one on the raw request vector.
- Issues a registered grant (index + one-hot) under a valid/ready handshake, then advances a rotating priority pointer so no requester starves.
- Sits between the request bitmap (per-slot pending flags) and the shared resource's issue port.

Parameters:
- CNTW, 16, width of the saturating accepted-grant counter.
- HOLD, 1, 1 = grant stays stable until accepted; 0 = grant is withdrawn if the granted requester drops req before acceptance.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- req  input  256  request bitmap, bit i = requester i pending.
- en  input  1  arbitration enable; low blocks issue of new grants.
- gnt_vld  output  1  grant valid.
- gnt_idx  output  8  granted requester index.
- gnt_oht  output  256  one-hot of gnt_idx; all zero when gnt_vld=0.
- gnt_rdy  input  1  consumer accepts the grant (handshake when gnt_vld&gnt_rdy).
- ptr  output  8  current round-robin pointer (highest-priority index).
- gnt_cnt  output  CNTW  number of accepted grants, saturating.

Behaviour:
- Reset (sync, rst high at clk edge): gnt_vld=0, gnt_idx=0, gnt_oht=0, ptr=0, gnt_cnt=0, state=IDLE. rst dominates all other inputs in the same cycle.
- Priority function: mask[i]=1 for i>=ptr. masked=req&mask.
  - If masked!=0, winner = lowest set index of masked.
  - Else winner = lowest set index of req.
  - Both encodes use pe256 (lowest set bit wins). The winner is the first requester at or after ptr, wrapping 255->0.
- State IDLE (gnt_vld=0): if en=1 and req!=0 at edge t, then at t+1: gnt_vld=1, gnt_idx=winner, gnt_oht=1<<winner, state=GRANT. Otherwise stay IDLE. Arbitration latency is 1 cycle.
- State GRANT (gnt_vld=1): gnt_idx and gnt_oht are held stable. en is ignored; an outstanding grant is never revoked by en.
  - Handshake (gnt_rdy=1 at edge):
    - Next cycle: gnt_vld=0, gnt_oht=0, state=IDLE.
    - ptr <= gnt_idx+1, mod 256 (255 -> 0).
    - gnt_cnt <= gnt_cnt+1, saturating at 2^CNTW-1.
    - gnt_idx keeps its last value.
  - HOLD=0 and req[gnt_idx]=0 with gnt_rdy=0: grant withdrawn next cycle (gnt_vld=0, state=IDLE). ptr and gnt_cnt unchanged.
  - HOLD=0 and req[gnt_idx]=0 with gnt_rdy=1 in the same cycle: the handshake wins.
  - HOLD=1: req changes never affect an outstanding grant.
- Throughput: at most one grant per 2 cycles. The cycle after a handshake is always a bubble (gnt_vld=0), during which the next arbitration uses the updated ptr.
- Single requester: it is re-granted every 2 cycles regardless of ptr.
- req=0 in IDLE: stay IDLE indefinitely; ptr unchanged.
- gnt_rdy while gnt_vld=0: ignored.
- Encoder valid outputs gate selection. An all-zero masked vector must not select the masked encoder's index.

Test Plan:
1. Reset: hold rst 2 cycles with req=all-ones, en=1, gnt_rdy=1 -> gnt_vld=0, ptr=0, gnt_cnt=0 during reset. First grant after release has gnt_idx=0 and appears 1 cycle after the first non-reset edge.
2. Rotation: req bits {3,100,255} set, gnt_rdy tied 1 -> grants 3, 100, 255, 3, each 2 cycles apart. ptr sequence is 4, 101, 0, 4. gnt_cnt=4.
3. Wrap and mask: set ptr to 250 via prior grant of 249, then req bits {5,250} -> grant 250, then 5, then 250.
4. Hold stability: grant to 17, keep gnt_rdy=0 for 10 cycles while toggling req and en -> gnt_idx=17 and gnt_oht=bit17 stable, gnt_vld=1 throughout (HOLD=1). Assert gnt_rdy -> gnt_vld=0 next cycle, ptr=18.
5. Withdraw (HOLD=0): grant to 42, drop req[42] with gnt_rdy=0 -> gnt_vld=0 next cycle, ptr unchanged, gnt_cnt unchanged. Repeat with gnt_rdy=1 in the same cycle -> counted handshake, ptr=43.
6. Saturation and mid-op reset (CNTW=4): 20 accepted grants -> gnt_cnt=15. Then rst during GRANT -> gnt_vld=0 and ptr=0 next cycle.

Source files
------------

// File: rtl/rr_arb256.sv
// Round-robin arbiter sharing one downstream resource among 256 requesters.
// A registered grant (index + one-hot) is issued under a valid/ready
// handshake. After each accepted grant the rotating priority pointer moves
// to one past the winner, so no requester starves.
//
// Ports:
//   clk      clock
//   rst      synchronous active-high reset
//   req      request bitmap, bit i = requester i pending
//   en       arbitration enable; low blocks issue of new grants
//   gnt_vld  grant valid
//   gnt_idx  granted requester index
//   gnt_oht  one-hot of gnt_idx, all zero while gnt_vld is low
//   gnt_rdy  consumer accepts the grant (handshake on gnt_vld & gnt_rdy)
//   ptr      current round-robin pointer (highest-priority index)
//   gnt_cnt  saturating count of accepted grants

// Lowest-set-bit priority encoder over a 256-bit vector.
module pe256 (
    input  logic [255:0] vec_i,
    output logic [7:0]   idx_o,
    output logic         vld_o
);
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = 255; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = 8'(i);
                vld_o = 1'b1;
            end
        end
    end
endmodule

module rr_arb256 #(
    parameter int unsigned CNTW = 16,
    parameter bit          HOLD = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [255:0]    req,
    input  logic            en,
    output logic            gnt_vld,
    output logic [7:0]      gnt_idx,
    output logic [255:0]    gnt_oht,
    input  logic            gnt_rdy,
    output logic [7:0]      ptr,
    output logic [CNTW-1:0] gnt_cnt
);
    localparam int unsigned N  = 256;
    localparam int unsigned IW = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q,   idx_d;
    logic [N-1:0]    oht_q,   oht_d;
    logic [IW-1:0]   ptr_q,   ptr_d;
    logic [CNTW-1:0] cnt_q,   cnt_d;

    logic [N-1:0]    mask_c;
    logic [N-1:0]    masked_c;
    logic [IW-1:0]   m_idx_c, r_idx_c, winner_c;
    logic            m_vld_c, r_vld_c;

    // Requesters at or above the pointer get first pick.
    assign mask_c   = {N{1'b1}} << ptr_q;
    assign masked_c = req & mask_c;

    pe256 u_pe_masked (
        .vec_i (masked_c),
        .idx_o (m_idx_c),
        .vld_o (m_vld_c)
    );

    pe256 u_pe_raw (
        .vec_i (req),
        .idx_o (r_idx_c),
        .vld_o (r_vld_c)
    );

    // Fall back to the raw encoder when nothing is pending at or above ptr,
    // which realises the 255 -> 0 wrap.
    assign winner_c = m_vld_c ? m_idx_c : r_idx_c;

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        oht_d   = oht_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (en && r_vld_c) begin
                    state_d = ST_GRANT;
                    idx_d   = winner_c;
                    oht_d   = N'(1) << winner_c;
                end
            end
            ST_GRANT: begin
                if (gnt_rdy) begin
                    state_d = ST_IDLE;
                    oht_d   = '0;
                    ptr_d   = idx_q + IW'(1);
                    if (cnt_q != {CNTW{1'b1}}) begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end else if (!HOLD && !req[idx_q]) begin
                    // Requester gave up before acceptance: withdraw quietly.
                    state_d = ST_IDLE;
                    oht_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                oht_d   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            oht_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            oht_q   <= oht_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_vld = (state_q == ST_GRANT);
    assign gnt_idx = idx_q;
    assign gnt_oht = oht_q;
    assign ptr     = ptr_q;
    assign gnt_cnt = cnt_q;

endmodule

// File: tb/tb_rr_arb256.sv
// Bench for rr_arb256: two instances (HOLD=1/CNTW=16 and HOLD=0/CNTW=4)
// share stimulus; each is compared every cycle against a behavioural model.
module tb_rr_arb256;
    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] req;
    logic         en;
    logic         gnt_rdy;

    logic         vld0, vld1;
    logic [7:0]   idx0, idx1, ptr0, ptr1;
    logic [255:0] oht0, oht1;
    logic [15:0]  cnt0;
    logic [3:0]   cnt1;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state, index 0 = HOLD=1 instance, 1 = HOLD=0 instance.
    bit m_busy [2];
    int m_idx  [2];
    int m_ptr  [2];
    int m_cnt  [2];
    int m_max  [2] = '{65535, 15};

    int grants [$];

    always #5 clk = ~clk;

    rr_arb256 #(.CNTW(16), .HOLD(1'b1)) u_dut_hold (
        .clk (clk), .rst (rst), .req (req), .en (en),
        .gnt_vld (vld0), .gnt_idx (idx0), .gnt_oht (oht0),
        .gnt_rdy (gnt_rdy), .ptr (ptr0), .gnt_cnt (cnt0)
    );

    rr_arb256 #(.CNTW(4), .HOLD(1'b0)) u_dut_nohold (
        .clk (clk), .rst (rst), .req (req), .en (en),
        .gnt_vld (vld1), .gnt_idx (idx1), .gnt_oht (oht1),
        .gnt_rdy (gnt_rdy), .ptr (ptr1), .gnt_cnt (cnt1)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First pending requester at or after p, walking upward with wrap.
    function automatic int rr_pick(input logic [255:0] r, input int p);
        for (int k = 0; k < 256; k++) begin
            if (r[(p + k) % 256]) return (p + k) % 256;
        end
        return -1;
    endfunction

    function automatic logic [255:0] onehot(input int i);
        logic [255:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_busy[k] = 1'b0; m_idx[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
            end else if (!m_busy[k]) begin
                if (en && req != '0) begin
                    m_busy[k] = 1'b1;
                    m_idx[k]  = rr_pick(req, m_ptr[k]);
                end
            end else if (gnt_rdy) begin
                m_busy[k] = 1'b0;
                m_ptr[k]  = (m_idx[k] + 1) % 256;
                if (m_cnt[k] < m_max[k]) m_cnt[k]++;
            end else if (k == 1 && !req[m_idx[k]]) begin
                m_busy[k] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        check("vld0", 256'(vld0), 256'(m_busy[0]));
        check("idx0", 256'(idx0), 256'(m_idx[0]));
        check("oht0", oht0, m_busy[0] ? onehot(m_idx[0]) : '0);
        check("ptr0", 256'(ptr0), 256'(m_ptr[0]));
        check("cnt0", 256'(cnt0), 256'(m_cnt[0]));
        check("vld1", 256'(vld1), 256'(m_busy[1]));
        check("idx1", 256'(idx1), 256'(m_idx[1]));
        check("oht1", oht1, m_busy[1] ? onehot(m_idx[1]) : '0);
        check("ptr1", 256'(ptr1), 256'(m_ptr[1]));
        check("cnt1", 256'(cnt1), 256'(m_cnt[1]));
    endtask

    // One clock: model takes the pre-edge inputs, DUT sampled 1 time unit later.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
        if (vld0 && !rst) grants.push_back(int'(idx0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [255:0] rand_req();
        logic [255:0] v;
        int mode;
        v = '0;
        mode = int'($urandom_range(0, 3));
        if (mode == 1) begin
            for (int j = 0; j < 8; j++) v[32*j +: 32] = $urandom;
        end else if (mode >= 2) begin
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) v[$urandom_range(0, 255)] = 1'b1;
        end
        return v;
    endfunction

    task automatic check_grants(input string tag, input int exp [$]);
        check({tag, "_n"}, 256'(grants.size()), 256'(exp.size()));
        for (int i = 0; i < exp.size() && i < grants.size(); i++)
            check(tag, 256'(grants[i]), 256'(exp[i]));
    endtask

    initial begin
        rst = 1'b1; req = '1; en = 1'b1; gnt_rdy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0; m_idx[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
        end

        // Reset held two cycles with everything active.
        step();
        step();
        check("rst_vld", 256'(vld0), 256'(0));
        check("rst_ptr", 256'(ptr0), 256'(0));
        rst = 1'b0;
        step();
        check("first_vld", 256'(vld0), 256'(1));
        check("first_idx", 256'(idx0), 256'(0));

        // Rotation across {3,100,255}.
        do_reset();
        req = '0; req[3] = 1'b1; req[100] = 1'b1; req[255] = 1'b1;
        gnt_rdy = 1'b1; en = 1'b1;
        grants.delete();
        step(); step();
        check("rot_ptr1", 256'(ptr0), 256'(4));
        step(); step();
        check("rot_ptr2", 256'(ptr0), 256'(101));
        step(); step();
        check("rot_ptr3", 256'(ptr0), 256'(0));
        step(); step();
        check("rot_ptr4", 256'(ptr0), 256'(4));
        check("rot_cnt", 256'(cnt0), 256'(4));
        check_grants("rot", '{3, 100, 255, 3});

        // Wrap and mask: ptr set to 250 via a grant to 249.
        do_reset();
        req = '0; req[249] = 1'b1;
        step(); step();
        check("wrap_ptr", 256'(ptr0), 256'(250));
        req = '0; req[5] = 1'b1; req[250] = 1'b1;
        grants.delete();
        for (int i = 0; i < 5; i++) step();
        check_grants("wrap", '{250, 5, 250});

        // Hold stability with gnt_rdy low while req/en toggle.
        do_reset();
        req = '0; req[17] = 1'b1; gnt_rdy = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            req = rand_req();
            en  = 1'($urandom);
            step();
            check("hold_idx", 256'(idx0), 256'(17));
            check("hold_vld", 256'(vld0), 256'(1));
            check("hold_oht", oht0, onehot(17));
        end
        gnt_rdy = 1'b1; en = 1'b1;
        step();
        check("hold_rel_vld", 256'(vld0), 256'(0));
        check("hold_rel_ptr", 256'(ptr0), 256'(18));

        // Withdraw on the HOLD=0 instance, then same-cycle drop + accept.
        do_reset();
        req = '0; req[42] = 1'b1; gnt_rdy = 1'b0;
        step();
        req = '0;
        step();
        check("wd_vld", 256'(vld1), 256'(0));
        check("wd_ptr", 256'(ptr1), 256'(0));
        check("wd_cnt", 256'(cnt1), 256'(0));
        req[42] = 1'b1;
        step();
        check("wd_regrant", 256'(idx1), 256'(42));
        req = '0; gnt_rdy = 1'b1;
        step();
        check("wd_hs_vld", 256'(vld1), 256'(0));
        check("wd_hs_ptr", 256'(ptr1), 256'(43));
        check("wd_hs_cnt", 256'(cnt1), 256'(1));

        // Saturation then reset while a grant is outstanding.
        do_reset();
        req = '1; gnt_rdy = 1'b1; en = 1'b1;
        for (int i = 0; i < 40; i++) step();
        check("sat_cnt1", 256'(cnt1), 256'(15));
        check("sat_cnt0", 256'(cnt0), 256'(20));
        gnt_rdy = 1'b0;
        step();
        check("midrst_pre", 256'(vld1), 256'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_vld", 256'(vld1), 256'(0));
        check("midrst_ptr", 256'(ptr1), 256'(0));

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            req     = rand_req();
            en      = ($urandom_range(0, 7) != 0);
            gnt_rdy = 1'($urandom);
            rst     = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
